// File: rtl/port_reader.sv
// Per-output-port packet reader: queues {length, pointer} descriptors and streams each packet out of the shared RAM.
// Optional macro PORT_READER_FREE_EN adds o_free_valid/o_free_ptr to return each finished packet's start pointer.
module port_reader #(
    parameter int pFIFO_WIDTH = 8,
    parameter int pDEPTH_RAM  = 256,
    parameter int pDATA_WIDTH = 8,
    parameter int pDESC_DEPTH = 4,
    localparam int AW = $clog2(pDEPTH_RAM)
) (
    input  logic                        iclk,
    input  logic                        irst,
    input  logic                        i_desc_valid,
    input  logic [pFIFO_WIDTH+AW-1:0]   i_desc,
    output logic                        o_desc_full,
    output logic                        o_desc_drop,
    output logic                        o_ram_rd_en,
    output logic [AW-1:0]               o_ram_addr,
    input  logic [pDATA_WIDTH-1:0]      i_ram_data,
    output logic [pDATA_WIDTH-1:0]      o_data,
    output logic                        o_valid,
    output logic                        o_sop,
    output logic                        o_eop,
    input  logic                        i_ready,
`ifdef PORT_READER_FREE_EN
    output logic                        o_free_valid,
    output logic [AW-1:0]               o_free_ptr,
`endif
    output logic                        o_busy
);

    localparam int DW = pFIFO_WIDTH + AW;
    localparam int PW = $clog2(pDESC_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;

    logic [DW-1:0]          desc_mem [pDESC_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   drop_q;
    logic                   full;
    logic                   wr_en;
    logic                   pop;
    logic [DW-1:0]          head;

    logic [1:0]             state;
    logic [pFIFO_WIDTH-1:0] len_q;
    logic [AW-1:0]          ptr_q;
    logic [AW-1:0]          addr_q;
    logic [pFIFO_WIDTH-1:0] remaining_q;
    logic                   first_q;

    logic                   rd_en;
    logic                   last_rd;
    logic                   valid_q;
    logic                   sop_q;
    logic                   eop_q;
`ifdef PORT_READER_FREE_EN
    logic                   free_valid_q;
    logic [AW-1:0]          free_ptr_q;
`endif

    assign full    = (count == CW'(pDESC_DEPTH));
    assign wr_en   = i_desc_valid && !full;
    assign pop     = (state == ST_IDLE) && (count != '0);
    assign head    = desc_mem[rd_ptr];
    assign rd_en   = (state == ST_READ) && i_ready && !irst;
    assign last_rd = rd_en && (remaining_q == pFIFO_WIDTH'(1));

    always_ff @(posedge iclk) begin
        if (wr_en) begin
            desc_mem[wr_ptr] <= i_desc;
        end
    end

    // A write while full is refused even if the FSM pops in the same cycle.
    always_ff @(posedge iclk) begin
        if (irst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count  <= count + CW'(wr_en) - CW'(pop);
            drop_q <= i_desc_valid && full;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            ptr_q       <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        len_q <= head[DW-1 -: pFIFO_WIDTH];
                        ptr_q <= head[AW-1:0];
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (len_q == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        addr_q      <= ptr_q;
                        remaining_q <= len_q;
                        first_q     <= 1'b1;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_en) begin
                        addr_q      <= addr_q + AW'(1);
                        remaining_q <= remaining_q - pFIFO_WIDTH'(1);
                        first_q     <= 1'b0;
                        if (remaining_q == pFIFO_WIDTH'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Framing bits travel with the read so they line up with the RAM's one-cycle latency.
    always_ff @(posedge iclk) begin
        if (irst) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            valid_q <= rd_en;
            sop_q   <= rd_en && first_q;
            eop_q   <= last_rd;
        end
    end

`ifdef PORT_READER_FREE_EN
    always_ff @(posedge iclk) begin
        if (irst) begin
            free_valid_q <= 1'b0;
            free_ptr_q   <= '0;
        end else begin
            free_valid_q <= last_rd || ((state == ST_LOAD) && (len_q == '0));
            if (last_rd || ((state == ST_LOAD) && (len_q == '0))) begin
                free_ptr_q <= ptr_q;
            end
        end
    end

    assign o_free_valid = free_valid_q;
    assign o_free_ptr   = free_ptr_q;
`endif

    // RAM output is already registered; gating with valid keeps o_data at zero between words and in reset.
    assign o_data      = valid_q ? i_ram_data : '0;
    assign o_valid     = valid_q;
    assign o_sop       = sop_q;
    assign o_eop       = eop_q;
    assign o_ram_rd_en = rd_en;
    assign o_ram_addr  = rd_en ? addr_q : '0;
    assign o_desc_full = full;
    assign o_desc_drop = drop_q;
    assign o_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_port_reader.sv
// Scoreboard bench for port_reader: a queue-based packet model predicts addresses, words and framing.
module tb_port_reader;

    localparam int FW = 8;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          iclk = 1'b0;
    logic          irst;
    logic          i_desc_valid;
    logic [FW+AW-1:0] i_desc;
    logic          o_desc_full;
    logic          o_desc_drop;
    logic          o_ram_rd_en;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] i_ram_data;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_sop;
    logic          o_eop;
    logic          i_ready;
    logic          o_busy;
`ifdef PORT_READER_FREE_EN
    logic          o_free_valid;
    logic [AW-1:0] o_free_ptr;
`endif

    logic [DW-1:0] mem [256];
    logic [DW-1:0] ram_q = '0;

    logic [AW-1:0]   exp_addr_q [$];
    logic [DW+1:0]   exp_word_q [$];
    logic [AW-1:0]   exp_free_q [$];

    int tests  = 0;
    int errors = 0;

    port_reader #(
        .pFIFO_WIDTH(FW),
        .pDEPTH_RAM(256),
        .pDATA_WIDTH(DW),
        .pDESC_DEPTH(4)
    ) dut (
        .iclk(iclk),
        .irst(irst),
        .i_desc_valid(i_desc_valid),
        .i_desc(i_desc),
        .o_desc_full(o_desc_full),
        .o_desc_drop(o_desc_drop),
        .o_ram_rd_en(o_ram_rd_en),
        .o_ram_addr(o_ram_addr),
        .i_ram_data(i_ram_data),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_sop(o_sop),
        .o_eop(o_eop),
        .i_ready(i_ready),
`ifdef PORT_READER_FREE_EN
        .o_free_valid(o_free_valid),
        .o_free_ptr(o_free_ptr),
`endif
        .o_busy(o_busy)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) begin
        if (o_ram_rd_en) begin
            ram_q <= mem[o_ram_addr];
        end
    end
    assign i_ram_data = ram_q;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // A packet is the run of RAM words starting at ptr, wrapping at the top of RAM.
    function automatic void modelPacket(input int len, input int ptr);
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = AW'((ptr + i) % 256);
            exp_addr_q.push_back(a);
            exp_word_q.push_back({i == 0, i == len - 1, mem[a]});
        end
        exp_free_q.push_back(AW'(ptr));
    endfunction

    task automatic applyStimulus(input int len, input int ptr, input bit accepted);
        i_desc       = {FW'(len), AW'(ptr)};
        i_desc_valid = 1'b1;
        if (accepted) begin
            modelPacket(len, ptr);
        end
        @(posedge iclk);
        #1;
        i_desc_valid = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, o_valid, 0);
        checkOutput({tag, "_data"}, o_data, 0);
        checkOutput({tag, "_sop_eop"}, {o_sop, o_eop}, 0);
        checkOutput({tag, "_rd_en"}, o_ram_rd_en, 0);
        checkOutput({tag, "_addr"}, o_ram_addr, 0);
        checkOutput({tag, "_busy"}, o_busy, 0);
        checkOutput({tag, "_full"}, o_desc_full, 0);
        checkOutput({tag, "_drop"}, o_desc_drop, 0);
`ifdef PORT_READER_FREE_EN
        checkOutput({tag, "_free_valid"}, o_free_valid, 0);
`endif
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((exp_addr_q.size() != 0 || exp_word_q.size() != 0
`ifdef PORT_READER_FREE_EN
                || exp_free_q.size() != 0
`endif
               ) && n < 2000) begin
            @(posedge iclk);
            n++;
        end
        checkOutput({tag, "_drain_in_time"}, n < 2000, 1);
        repeat (3) @(posedge iclk);
        #1;
    endtask

    always @(negedge iclk) begin
        if (o_ram_rd_en) begin
            checkOutput("read_only_when_ready", i_ready, 1);
            checkOutput("read_expected", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0) begin
                checkOutput("read_addr", o_ram_addr, exp_addr_q.pop_front());
            end
        end
        if (o_valid) begin
            checkOutput("word_expected", exp_word_q.size() != 0, 1);
            if (exp_word_q.size() != 0) begin
                checkOutput("word_sop_eop_data", {o_sop, o_eop, o_data}, exp_word_q.pop_front());
            end
        end
`ifdef PORT_READER_FREE_EN
        if (o_free_valid) begin
            checkOutput("free_expected", exp_free_q.size() != 0, 1);
            if (exp_free_q.size() != 0) begin
                checkOutput("free_ptr", o_free_ptr, exp_free_q.pop_front());
            end
        end
`endif
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        irst         = 1'b1;
        i_desc_valid = 1'b0;
        i_desc       = '0;
        i_ready      = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = DW'($urandom);
        end
        repeat (3) @(posedge iclk);
        #1;
        checkIdleOutputs("reset");
        irst = 1'b0;
        @(posedge iclk);
        #1;

        // Latency and consecutive addresses with ready held high.
        i_ready = 1'b1;
        applyStimulus(3, 'h10, 1);
        @(negedge iclk);
        checkOutput("t1_no_read_k0", o_ram_rd_en, 0);
        @(negedge iclk);
        checkOutput("t1_no_read_k1", o_ram_rd_en, 0);
        @(negedge iclk);
        checkOutput("t1_read0", {o_ram_rd_en, o_ram_addr}, {1'b1, 8'h10});
        @(negedge iclk);
        checkOutput("t1_read1", {o_ram_rd_en, o_ram_addr}, {1'b1, 8'h11});
        @(negedge iclk);
        checkOutput("t1_read2", {o_ram_rd_en, o_ram_addr}, {1'b1, 8'h12});
        checkOutput("t1_busy_during", o_busy, 1);
        @(negedge iclk);
        checkOutput("t1_busy_after", o_busy, 0);
        checkOutput("t1_no_read_after", o_ram_rd_en, 0);
        waitDrain("t1");

        applyStimulus(4, 'hFE, 1);
        waitDrain("t2_wrap");

        // Park a packet in READ, then overfill the descriptor FIFO.
        i_ready = 1'b0;
        applyStimulus(2, 'h50, 1);
        repeat (3) @(posedge iclk);
        #1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3, 'h60 + 8 * i, i < 4);
            if (i == 2) checkOutput("t3_not_full_after_3", o_desc_full, 0);
            if (i == 3) checkOutput("t3_full_after_4", o_desc_full, 1);
            if (i == 4) checkOutput("t3_drop_pulse", o_desc_drop, 1);
        end
        @(posedge iclk);
        #1;
        checkOutput("t3_drop_one_cycle", o_desc_drop, 0);
        i_ready = 1'b1;
        waitDrain("t3");

        applyStimulus(4, 'h80, 1);
        for (int c = 0; c < 16; c++) begin
            i_ready = (c % 2 == 0);
            @(posedge iclk);
            #1;
        end
        i_ready = 1'b1;
        waitDrain("t4_toggle");

        applyStimulus(0, 'h20, 1);
        applyStimulus(1, 'h30, 1);
        waitDrain("t5_zero_len");

        // Reset in the middle of a packet with two descriptors still queued.
        applyStimulus(8, 'h40, 1);
        applyStimulus(2, 'h90, 1);
        applyStimulus(3, 'hA0, 1);
        repeat (2) @(posedge iclk);
        #1;
        irst = 1'b1;
        @(posedge iclk);
        #1;
        exp_addr_q.delete();
        exp_word_q.delete();
        exp_free_q.delete();
        checkIdleOutputs("mid_reset");
        irst = 1'b0;
        repeat (10) @(posedge iclk);
        #1;
        checkOutput("mid_reset_stays_idle", o_busy, 0);
        checkOutput("mid_reset_fifo_empty", o_desc_full, 0);

        for (int cyc = 0; cyc < 400; cyc++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 3 && !o_desc_full) begin
                applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 255)), 1);
            end else begin
                @(posedge iclk);
                #1;
            end
        end
        i_ready = 1'b1;
        waitDrain("random");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/port_reader.md
Name: port_reader

Overview:
- Downstream of the pre-arbiter. One instance per output port.
- Buffers packet descriptors {length, pointer} from that port's pre-arbiter FIFO output in a small descriptor FIFO.
- Serves descriptors in order: streams each packet's words out of the shared packet RAM, with SOP/EOP framing and ready-gated reads.

Parameters:
pFIFO_WIDTH, 8, width of the length field (packet length in RAM words).
pDEPTH_RAM, 256, packet RAM depth in words; must be a power of 2; AW = $clog2(pDEPTH_RAM).
pDATA_WIDTH, 8, RAM word width.
pDESC_DEPTH, 4, descriptor FIFO entries; must be a power of 2, at least 2.

Ports:
iclk  in  1  clock; all logic on the rising edge.
irst  in  1  reset; synchronous, active-high.
i_desc_valid  in  1  descriptor write strobe, one per descriptor.
i_desc  in  pFIFO_WIDTH+AW  descriptor: length in [MSB -: pFIFO_WIDTH], start pointer in [AW-1:0].
o_desc_full  out  1  descriptor FIFO full.
o_desc_drop  out  1  one-cycle pulse: write attempted while full.
o_ram_rd_en  out  1  RAM read strobe.
o_ram_addr  out  AW  RAM read address.
i_ram_data  in  pDATA_WIDTH  RAM read data; valid 1 cycle after o_ram_rd_en.
o_data  out  pDATA_WIDTH  packet word.
o_valid  out  1  o_data valid.
o_sop  out  1  first word of packet; qualified by o_valid.
o_eop  out  1  last word of packet; qualified by o_valid.
i_ready  in  1  sink can take the word produced by a read issued this cycle.
o_busy  out  1  state is not IDLE.

Behaviour:
Reset:
- While irst is high at an edge: FIFO empty, state IDLE.
- All outputs 0, including o_data and o_ram_addr.
- Any packet in progress is abandoned with no EOP. Queued descriptors are discarded.

Descriptor FIFO:
- Write when i_desc_valid=1 and not full.
- Write while full is rejected, even if a pop occurs in the same cycle; o_desc_drop pulses the next cycle.
- Registered count; o_desc_full = (count == pDESC_DEPTH).
- Simultaneous write and pop when not full: count unchanged.

FSM:
- IDLE:
  - If count != 0: pop head into length/pointer registers, then LOAD.
- LOAD:
  - If length == 0: discard descriptor, go to IDLE. No RAM access, no output.
  - Else: addr = pointer, remaining = length, first = 1, go to READ.
- READ:
  - In each cycle with i_ready=1: o_ram_rd_en=1 and o_ram_addr=addr.
  - Then addr = addr+1 modulo pDEPTH_RAM (natural wrap from pDEPTH_RAM-1 to 0), and remaining decrements.
  - The read with remaining==1 is the last read; go to IDLE next.
  - With i_ready=0: o_ram_rd_en=0, no state change.

Output stage:
- o_valid is o_ram_rd_en delayed 1 cycle. o_data = i_ram_data in that cycle.
- o_sop marks the word from the first read; o_eop marks the word from the last read.
- Length 1: o_sop and o_eop asserted together.

Timing:
- Descriptor written at edge k into an empty FIFO → popped at edge k+1 → first o_ram_rd_en in the cycle after edge k+2 (with i_ready=1) → first o_valid one cycle later.
- With i_ready held high, a packet of length L occupies L consecutive read cycles.
- Back-to-back packets have 2 idle cycles between them (IDLE, LOAD).

o_ram_rd_en and o_ram_addr are combinational from state and i_ready. All other outputs are registered.

Optional Feature:
Macro PORT_READER_FREE_EN.
- Defined: adds outputs o_free_valid (1) and o_free_ptr (AW).
  - o_free_valid pulses for one cycle, coincident with the o_eop word.
  - o_free_ptr carries that packet's start pointer, returning the buffer to the free-pointer list.
  - Zero-length descriptors also pulse o_free_valid in the cycle after LOAD.
- Undefined: the ports do not exist; no free-list signalling.

Test Plan:
- Reset; write {len=3, ptr=0x10}; i_ready=1 → addr 0x10, 0x11, 0x12 on consecutive cycles; o_sop on word 0x10, o_eop on word 0x12; o_busy drops after.
- Write {len=4, ptr=0xFE} → addresses 0xFE, 0xFF, 0x00, 0x01; data matches the RAM model.
- Write 5 descriptors back-to-back with i_ready=0 → o_desc_full after the 4th; 5th gives one o_desc_drop pulse; the 4 stored packets stream in order once i_ready=1.
- Toggle i_ready 1,0,1,0 during a len=4 packet → reads only on ready cycles; word order and SOP/EOP intact.
- {len=0, ptr=0x20} followed by {len=1, ptr=0x30} → no read for 0x20; single word at 0x30 with o_sop=o_eop=1. With PORT_READER_FREE_EN: o_free_ptr pulses 0x20, then 0x30.
- Assert irst mid-packet with 2 descriptors queued → all outputs 0 the next cycle; no further reads; FIFO empty.
